// File: rtl/bus_codes_pkg.sv
// Shared bus code table.
// Source-select and destination codes use the same 5-bit encoding, so both
// sides of the bus import this package. Also holds the pair-write FSM state
// encoding used by the destination register block.
package bus_codes_pkg;

    localparam int CODE_W   = 5;
    localparam int NUM_DEST = 24;  // codes 0..23 have a slot; 24..31 are illegal

    localparam logic [CODE_W-1:0] CODE_R0   = 5'd0;
    localparam logic [CODE_W-1:0] CODE_R15  = 5'd15;
    localparam logic [CODE_W-1:0] CODE_HI   = 5'd16;
    localparam logic [CODE_W-1:0] CODE_LO   = 5'd17;
    localparam logic [CODE_W-1:0] CODE_ZHI  = 5'd18;
    localparam logic [CODE_W-1:0] CODE_ZLO  = 5'd19;
    localparam logic [CODE_W-1:0] CODE_PC   = 5'd20;
    localparam logic [CODE_W-1:0] CODE_MDR  = 5'd21;
    localparam logic [CODE_W-1:0] CODE_PORT = 5'd22;
    localparam logic [CODE_W-1:0] CODE_SIGN = 5'd23;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAIR_LO = 1'b1
    } pair_state_t;

endpackage

// File: rtl/bus_dest_decoder.sv
// Destination code decoder.
// Turns a 5-bit bus code into a one-hot load enable over the 24 code slots.
// Read-only codes (ZHI, ZLO, SIGN) and illegal codes (24..31) produce no
// enable and raise ro_or_illegal instead.
// Ports:
//   code          in   CODE_W     destination code
//   ld_en         out  NUM_DEST   one-hot load enable, bit n = code n
//   ro_or_illegal out  1          code cannot be written
module bus_dest_decoder
    import bus_codes_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [NUM_DEST-1:0] ld_en,
    output logic                ro_or_illegal
);

    always_comb begin
        ld_en         = '0;
        ro_or_illegal = 1'b0;
        case (code)
            CODE_ZHI, CODE_ZLO, CODE_SIGN: ro_or_illegal = 1'b1;
            default: begin
                if (code[4:3] == 2'b11) begin
                    ro_or_illegal = 1'b1;
                end else begin
                    ld_en = {{(NUM_DEST-1){1'b0}}, 1'b1} << code;
                end
            end
        endcase
    end

endmodule

// File: rtl/bus_dest_regs.sv
// Write side of the internal datapath bus.
// Captures bus_in into the register named by wr_dest and drives all writable
// registers back out as bus sources. Supports a two-beat HI/LO pair write for
// 64-bit mul/div results and a PC auto-increment.
// Ports:
//   clk, clr       clock, asynchronous active-high reset
//   bus_in         data to capture
//   wr_dest        destination code
//   wr_valid       write request; accepted when wr_valid & wr_ready
//   wr_pair        with wr_dest=HI, opens a HI/LO pair write
//   wr_ready       ~hold
//   hold           memory owns MDR, stalls all writes
//   pc_inc         increment PC (a bus write to PC takes priority)
//   rf_q           R0..R15 flattened, R(n) = rf_q[n*WIDTH +: WIDTH]
//   hi_q, lo_q, pc_q, mdr_q, port_q   register outputs
//   pair_pend      HI beat taken, LO beat outstanding
//   wr_err         one-cycle pulse after an accepted read-only/illegal write
module bus_dest_regs
    import bus_codes_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter bit               R0_ZERO  = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [WIDTH-1:0]    bus_in,
    input  logic [CODE_W-1:0]   wr_dest,
    input  logic                wr_valid,
    input  logic                wr_pair,
    output logic                wr_ready,
    input  logic                hold,
    input  logic                pc_inc,
    output logic [16*WIDTH-1:0] rf_q,
    output logic [WIDTH-1:0]    hi_q,
    output logic [WIDTH-1:0]    lo_q,
    output logic [WIDTH-1:0]    pc_q,
    output logic [WIDTH-1:0]    mdr_q,
    output logic [WIDTH-1:0]    port_q,
    output logic                pair_pend,
    output logic                wr_err
);

    // Dropping code 0 at the enable level keeps R0 at its reset value of 0.
    localparam logic [NUM_DEST-1:0] R0_MASK =
        R0_ZERO ? {{(NUM_DEST-1){1'b0}}, 1'b1} : '0;

    logic [WIDTH-1:0]    rf [16];
    logic [WIDTH-1:0]    hi, lo, pc, mdr, port;
    pair_state_t         state, state_d;
    logic                err_d;
    logic                accept;
    logic [NUM_DEST-1:0] dec_ld;
    logic                dec_ro;
    logic [NUM_DEST-1:0] ld_en;
    logic                unused_ro_bits;

    bus_dest_decoder u_dec (
        .code          (wr_dest),
        .ld_en         (dec_ld),
        .ro_or_illegal (dec_ro)
    );

    assign wr_ready = ~hold;
    assign accept   = wr_valid & ~hold;

    // Read-only slots never carry an enable; sink them.
    assign unused_ro_bits = ^{ld_en[CODE_ZHI], ld_en[CODE_ZLO], ld_en[CODE_SIGN]};

    // Pair FSM and load-enable selection. In PAIR_LO the accepted beat goes
    // to LO regardless of wr_dest/wr_pair, and never reports an error.
    always_comb begin
        state_d = state;
        ld_en   = '0;
        err_d   = 1'b0;
        if (accept) begin
            if (state == ST_PAIR_LO) begin
                ld_en[CODE_LO] = 1'b1;
                state_d        = ST_IDLE;
            end else begin
                ld_en = dec_ld & ~R0_MASK;
                err_d = dec_ro;
                if (wr_pair && (wr_dest == CODE_HI)) begin
                    state_d = ST_PAIR_LO;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            hi     <= '0;
            lo     <= '0;
            pc     <= RESET_PC;
            mdr    <= '0;
            port   <= '0;
            state  <= ST_IDLE;
            wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (ld_en[i]) rf[i] <= bus_in;
            end
            if (ld_en[CODE_HI])   hi   <= bus_in;
            if (ld_en[CODE_LO])   lo   <= bus_in;
            if (ld_en[CODE_MDR])  mdr  <= bus_in;
            if (ld_en[CODE_PORT]) port <= bus_in;
            // Bus write beats increment; addition wraps modulo 2^WIDTH.
            if (ld_en[CODE_PC])   pc   <= bus_in;
            else if (pc_inc)      pc   <= pc + 1'b1;
            state  <= state_d;
            wr_err <= err_d;
        end
    end

    for (genvar n = 0; n < 16; n++) begin : g_rf_out
        if (R0_ZERO && n == 0) begin : g_zero
            assign rf_q[n*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            assign rf_q[n*WIDTH +: WIDTH] = rf[n];
        end
    end

    assign hi_q      = hi;
    assign lo_q      = lo;
    assign pc_q      = pc;
    assign mdr_q     = mdr;
    assign port_q    = port;
    assign pair_pend = (state == ST_PAIR_LO);

endmodule

// File: tb/tb_bus_dest_regs.sv
// Directed bench for bus_dest_regs: a table of single writes followed by
// hand-written sequences for pair writes, hold, PC wrap and mid-pair reset.
// A second instance with R0_ZERO=0 shares all inputs.
module tb_bus_dest_regs;

    logic         clk = 1'b0;
    logic         clr;
    logic [31:0]  bus_in;
    logic [4:0]   wr_dest;
    logic         wr_valid, wr_pair, hold, pc_inc;
    logic         wr_ready, pair_pend, wr_err;
    logic [511:0] rf_q;
    logic [31:0]  hi_q, lo_q, pc_q, mdr_q, port_q;

    logic         wr_ready_b, pair_pend_b, wr_err_b;
    logic [511:0] rf_q_b;
    logic [31:0]  hi_q_b, lo_q_b, pc_q_b, mdr_q_b, port_q_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_dest_regs #(.WIDTH(32), .RESET_PC(32'h100), .R0_ZERO(1'b1)) u_dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .wr_dest(wr_dest),
        .wr_valid(wr_valid), .wr_pair(wr_pair), .wr_ready(wr_ready),
        .hold(hold), .pc_inc(pc_inc), .rf_q(rf_q), .hi_q(hi_q), .lo_q(lo_q),
        .pc_q(pc_q), .mdr_q(mdr_q), .port_q(port_q), .pair_pend(pair_pend),
        .wr_err(wr_err)
    );

    bus_dest_regs #(.WIDTH(32), .RESET_PC(32'h100), .R0_ZERO(1'b0)) u_dut_b (
        .clk(clk), .clr(clr), .bus_in(bus_in), .wr_dest(wr_dest),
        .wr_valid(wr_valid), .wr_pair(wr_pair), .wr_ready(wr_ready_b),
        .hold(hold), .pc_inc(pc_inc), .rf_q(rf_q_b), .hi_q(hi_q_b), .lo_q(lo_q_b),
        .pc_q(pc_q_b), .mdr_q(mdr_q_b), .port_q(port_q_b), .pair_pend(pair_pend_b),
        .wr_err(wr_err_b)
    );

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        pair;
        logic [4:0]  chk;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] rd(input logic [4:0] c);
        logic [31:0] v;
        v = 32'hXXXX_XXXX;
        if (c < 5'd16) v = rf_q[c*32 +: 32];
        else if (c == 5'd16) v = hi_q;
        else if (c == 5'd17) v = lo_q;
        else if (c == 5'd20) v = pc_q;
        else if (c == 5'd21) v = mdr_q;
        else if (c == 5'd22) v = port_q;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, release after the rising edge.
    task automatic step(input logic [4:0] d, input logic [31:0] v, input logic p,
                        input logic inc, input logic val);
        @(negedge clk);
        wr_dest  = d;
        bus_in   = v;
        wr_pair  = p;
        pc_inc   = inc;
        wr_valid = val;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_pair  = 1'b0;
        pc_inc   = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[1]  = '{5'd4,  32'h00000000, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[2]  = '{5'd0,  32'h00001234, 1'b0, 5'd0,  32'h00000000, 1'b0};
        vecs[3]  = '{5'd3,  32'h00000033, 1'b0, 5'd3,  32'h00000033, 1'b0};
        vecs[4]  = '{5'd16, 32'h11112222, 1'b0, 5'd16, 32'h11112222, 1'b0};
        vecs[5]  = '{5'd17, 32'h33334444, 1'b0, 5'd17, 32'h33334444, 1'b0};
        vecs[6]  = '{5'd21, 32'h55556666, 1'b1, 5'd21, 32'h55556666, 1'b0};
        vecs[7]  = '{5'd22, 32'h77778888, 1'b0, 5'd22, 32'h77778888, 1'b0};
        vecs[8]  = '{5'd15, 32'h0F0F0F0F, 1'b0, 5'd15, 32'h0F0F0F0F, 1'b0};
        vecs[9]  = '{5'd19, 32'hCAFEF00D, 1'b0, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[10] = '{5'd27, 32'hCAFEF00D, 1'b0, 5'd22, 32'h77778888, 1'b1};
        vecs[11] = '{5'd18, 32'hCAFEF00D, 1'b0, 5'd16, 32'h11112222, 1'b1};
        vecs[12] = '{5'd20, 32'hFFFFFFFF, 1'b0, 5'd20, 32'hFFFFFFFF, 1'b0};

        clr = 1'b1; bus_in = '0; wr_dest = '0; wr_valid = 1'b0;
        wr_pair = 1'b0; hold = 1'b0; pc_inc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rf", rf_q[31:0] | rf_q[511:480] | rf_q[191:160], 32'h0);
        check("reset pc", pc_q, 32'h100);
        check("reset hi|lo|mdr|port", hi_q | lo_q | mdr_q | port_q, 32'h0);
        check("reset pair_pend", {31'b0, pair_pend}, 32'h0);
        check("reset wr_err", {31'b0, wr_err}, 32'h0);
        check("wr_ready idle", {31'b0, wr_ready}, 32'h1);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].dest, vecs[i].data, vecs[i].pair, 1'b0, 1'b1);
            check($sformatf("vec%0d reg", i), rd(vecs[i].chk), vecs[i].exp);
            check($sformatf("vec%0d wr_err", i), {31'b0, wr_err}, {31'b0, vecs[i].err});
            check($sformatf("vec%0d pair_pend", i), {31'b0, pair_pend}, 32'h0);
            if (i == 2) check("R0_ZERO=0 R0", rf_q_b[31:0], 32'h00001234);
        end
        check("R4 untouched by R5", rf_q[4*32 +: 32], 32'h0);

        // Error pulse lasts exactly one cycle
        step(5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("wr_err falls", {31'b0, wr_err}, 32'h0);
        check("ro writes left hi", hi_q, 32'h11112222);

        // PC wrap, then bus write beats increment
        step(5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("pc wrap", pc_q, 32'h0);
        step(5'd20, 32'h40, 1'b0, 1'b1, 1'b1);
        check("pc write beats inc", pc_q, 32'h40);

        // Pair write, no hold
        step(5'd16, 32'hAAAA0000, 1'b1, 1'b0, 1'b1);
        check("pair hi", hi_q, 32'hAAAA0000);
        check("pair_pend set", {31'b0, pair_pend}, 32'h1);
        step(5'd3, 32'h0000BBBB, 1'b0, 1'b0, 1'b1);
        check("pair lo", lo_q, 32'h0000BBBB);
        check("pair R3 kept", rf_q[3*32 +: 32], 32'h00000033);
        check("pair_pend clear", {31'b0, pair_pend}, 32'h0);
        check("pair no err", {31'b0, wr_err}, 32'h0);

        // Pair write with 3 held cycles between beats
        step(5'd16, 32'h12340000, 1'b1, 1'b0, 1'b1);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            hold = 1'b1; wr_valid = 1'b1; wr_dest = 5'd3; bus_in = 32'h9999;
            #1;
            check($sformatf("hold%0d wr_ready", h), {31'b0, wr_ready}, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d pair_pend", h), {31'b0, pair_pend}, 32'h1);
            check($sformatf("hold%0d lo", h), lo_q, 32'h0000BBBB);
        end
        @(negedge clk);
        hold = 1'b0; wr_valid = 1'b0;
        step(5'd3, 32'h00005678, 1'b0, 1'b0, 1'b1);
        check("held pair lo", lo_q, 32'h00005678);
        check("held pair hi", hi_q, 32'h12340000);
        check("held pair_pend clear", {31'b0, pair_pend}, 32'h0);

        // Reset in the middle of a pair
        step(5'd16, 32'hFEED0000, 1'b1, 1'b0, 1'b1);
        check("mid pair pend", {31'b0, pair_pend}, 32'h1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("async clr pair_pend", {31'b0, pair_pend}, 32'h0);
        check("async clr hi", hi_q, 32'h0);
        check("async clr pc", pc_q, 32'h100);
        check("async clr R5", rf_q[5*32 +: 32], 32'h0);
        @(negedge clk);
        clr = 1'b0;
        step(5'd17, 32'h00000099, 1'b0, 1'b0, 1'b1);
        check("post clr lo", lo_q, 32'h00000099);
        check("post clr hi", hi_q, 32'h0);
        check("post clr pair_pend", {31'b0, pair_pend}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
